// File: rtl/cache_types.sv
// Cache-wide constants (cache_consts: LLC_WAYS, INVALID, overridable on the command line)
// and the LLC field types shared by the tag pipeline.
`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif
`ifndef INVALID
`define INVALID 0
`endif

package cache_types;
    localparam int LLC_WAYS = `LLC_WAYS;

    typedef logic [15:0]                   llc_tag_t;
    typedef logic [2:0]                    llc_state_t;
    typedef logic [$clog2(LLC_WAYS)-1:0]   llc_way_t;

    localparam llc_state_t LLC_INVALID = llc_state_t'(`INVALID);
endpackage

// File: rtl/llc_victim_sel_pkg.sv
// Shared definitions for the LLC victim selector: FSM states and scan constants.
package llc_victim_sel_pkg;
    import cache_types::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } vsel_state_e;

    localparam llc_way_t LAST_WAY = llc_way_t'(LLC_WAYS - 1);
endpackage

// File: rtl/llc_way_cmp.sv
// Single-way classifier: flags a tag hit on a valid line, or an empty way.
// Purely combinational, no flow control.
module llc_way_cmp
    import cache_types::*;
(
    input  llc_tag_t   way_tag,
    input  llc_state_t way_state,
    input  llc_tag_t   req_tag,
    output logic       way_hit,
    output logic       way_inv
);
    assign way_inv = (way_state == LLC_INVALID);
    assign way_hit = !way_inv && (way_tag == req_tag);
endmodule

// File: rtl/llc_victim_sel.sv
// LLC victim selector: scans one way per cycle, picks hit > first invalid > round-robin victim.
// Latency start->done is LLC_WAYS+1, or hit_index+2 with LLC_VICTIM_EARLY_EXIT_EN; start while busy is dropped.
module llc_victim_sel
    import cache_types::*;
    import llc_victim_sel_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_state,
    input  logic       start,
    input  llc_tag_t   req_tag,
    input  llc_tag_t   tags_buf   [LLC_WAYS],
    input  llc_state_t states_buf [LLC_WAYS],
    input  llc_way_t   evict_way_buf,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output llc_way_t   way,
    output logic       evict,
    output logic       incr_evict_way_buf
);
`ifdef LLC_VICTIM_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    vsel_state_e state_q, state_d;
    llc_way_t    cnt_q, cnt_d;
    logic        hit_q, hit_d;
    llc_way_t    hit_way_q, hit_way_d;
    logic        inv_q, inv_d;
    llc_way_t    inv_way_q, inv_way_d;
    llc_way_t    way_q, way_d;
    logic        evict_q, evict_d;

    logic        cur_hit, cur_inv;
    logic        scan_hit, scan_inv;
    llc_way_t    scan_hit_way, scan_inv_way;

    llc_way_cmp u_way_cmp (
        .way_tag   (tags_buf[cnt_q]),
        .way_state (states_buf[cnt_q]),
        .req_tag   (req_tag),
        .way_hit   (cur_hit),
        .way_inv   (cur_inv)
    );

    // First hit and first invalid way win; later matches never overwrite them.
    assign scan_hit     = hit_q || cur_hit;
    assign scan_hit_way = hit_q ? hit_way_q : cnt_q;
    assign scan_inv     = inv_q || cur_inv;
    assign scan_inv_way = inv_q ? inv_way_q : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        inv_d     = inv_q;
        inv_way_d = inv_way_q;
        way_d     = way_q;
        evict_d   = evict_q;
        if (rst_state) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hit_d     = 1'b0;
            hit_way_d = '0;
            inv_d     = 1'b0;
            inv_way_d = '0;
            way_d     = '0;
            evict_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SCAN;
                        cnt_d     = '0;
                        hit_d     = 1'b0;
                        hit_way_d = '0;
                        inv_d     = 1'b0;
                        inv_way_d = '0;
                        way_d     = '0;
                        evict_d   = 1'b0;
                    end
                end
                ST_SCAN: begin
                    cnt_d     = cnt_q + llc_way_t'(1);
                    hit_d     = scan_hit;
                    hit_way_d = scan_hit_way;
                    inv_d     = scan_inv;
                    inv_way_d = scan_inv_way;
                    if ((cnt_q == LAST_WAY) || (EARLY_EXIT && cur_hit)) begin
                        state_d = ST_DONE;
                        way_d   = scan_hit ? scan_hit_way :
                                  scan_inv ? scan_inv_way : evict_way_buf;
                        evict_d = !scan_hit && !scan_inv;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            inv_q     <= 1'b0;
            inv_way_q <= '0;
            way_q     <= '0;
            evict_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            inv_q     <= inv_d;
            inv_way_q <= inv_way_d;
            way_q     <= way_d;
            evict_q   <= evict_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign hit                = hit_q;
    assign way                = way_q;
    assign evict              = evict_q;
    assign incr_evict_way_buf = done && evict_q;
endmodule

// File: tb/tb_llc_victim_sel.sv
// Self-checking bench for llc_victim_sel: directed scenarios plus randomized sets vs a priority model.
module tb_llc_victim_sel;
    import cache_types::*;

`ifdef LLC_VICTIM_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_state;
    logic       start;
    llc_tag_t   req_tag;
    llc_tag_t   tags_buf   [LLC_WAYS];
    llc_state_t states_buf [LLC_WAYS];
    llc_way_t   evict_way_buf;
    logic       busy, done, hit, evict, incr_evict_way_buf;
    llc_way_t   way;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    llc_victim_sel dut (
        .clk                (clk),
        .rst                (rst),
        .rst_state          (rst_state),
        .start              (start),
        .req_tag            (req_tag),
        .tags_buf           (tags_buf),
        .states_buf         (states_buf),
        .evict_way_buf      (evict_way_buf),
        .busy               (busy),
        .done               (done),
        .hit                (hit),
        .way                (way),
        .evict              (evict),
        .incr_evict_way_buf (incr_evict_way_buf)
    );

    // Reference: hit beats first empty way beats the round-robin pointer.
    function automatic void model(output logic m_hit, output llc_way_t m_way,
                                  output logic m_evict, output int m_lat);
        int hit_idx = -1;
        int inv_idx = -1;
        for (int i = 0; i < LLC_WAYS; i++) begin
            if (hit_idx < 0 && states_buf[i] != LLC_INVALID && tags_buf[i] == req_tag) hit_idx = i;
            if (inv_idx < 0 && states_buf[i] == LLC_INVALID) inv_idx = i;
        end
        m_hit   = (hit_idx >= 0);
        m_evict = (hit_idx < 0) && (inv_idx < 0);
        if (hit_idx >= 0)      m_way = llc_way_t'(hit_idx);
        else if (inv_idx >= 0) m_way = llc_way_t'(inv_idx);
        else                   m_way = evict_way_buf;
        m_lat = (EARLY && hit_idx >= 0) ? hit_idx + 2 : LLC_WAYS + 1;
    endfunction

    task automatic fill_all_valid();
        for (int i = 0; i < LLC_WAYS; i++) begin
            states_buf[i] = 3'd1;
            tags_buf[i]   = llc_tag_t'(16'h0100 + i);
        end
        req_tag = 16'h003A;
    endtask

    // Pulses start and follows the scan to its done strobe; compares nothing itself.
    task automatic do_scan(output int lat, output logic o_hit, output llc_way_t o_way,
                           output logic o_evict, output logic o_incr, output int stray,
                           output logic post_busy, output logic post_done);
        stray = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (incr_evict_way_buf !== 1'b0) stray++;
            @(posedge clk); #1;
            lat++;
        end
        o_hit = hit; o_way = way; o_evict = evict; o_incr = incr_evict_way_buf;
        @(posedge clk); #1;
        post_busy = busy; post_done = done;
        if (incr_evict_way_buf !== 1'b0) stray++;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst_state = 1'b0; start = 1'b1; evict_way_buf = '0;
        fill_all_valid();
        repeat (3) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        compared++; if ({hit, evict, incr_evict_way_buf} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {hit, evict, incr_evict_way_buf}); end
        compared++; if (way !== llc_way_t'(0)) begin mismatched++; $display("FAIL reset_way: got %0d want 0", way); end
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midscan();
        int dones = 0;
        fill_all_valid();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midscan_reset_busy: got %b want 0", busy); end
        @(posedge clk); #1; rst = 1'b1;
        repeat (25) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        compared++; if (dones != 0) begin mismatched++; $display("FAIL midscan_reset_done: got %0d dones want 0", dones); end
    endtask

    task automatic test_hit();
        int lat, stray; logic h, e, inc, pb, pd; llc_way_t w;
        fill_all_valid();
        tags_buf[5] = 16'h003A;
        evict_way_buf = llc_way_t'(2);
        do_scan(lat, h, w, e, inc, stray, pb, pd);
        compared++; if (lat != (EARLY ? 7 : 17)) begin mismatched++; $display("FAIL hit_latency: got %0d want %0d", lat, EARLY ? 7 : 17); end
        compared++; if (h !== 1'b1) begin mismatched++; $display("FAIL hit_flag: got %b want 1", h); end
        compared++; if (w !== llc_way_t'(5)) begin mismatched++; $display("FAIL hit_way: got %0d want 5", w); end
        compared++; if ({e, inc} !== 2'b00) begin mismatched++; $display("FAIL hit_evict_incr: got %b want 00", {e, inc}); end
        compared++; if ({pb, pd} !== 2'b00) begin mismatched++; $display("FAIL hit_after_done: busy/done got %b want 00", {pb, pd}); end
    endtask

    task automatic test_invalid_fill();
        int lat, stray; logic h, e, inc, pb, pd; llc_way_t w;
        fill_all_valid();
        states_buf[3] = LLC_INVALID;
        states_buf[9] = LLC_INVALID;
        evict_way_buf = llc_way_t'(7);
        do_scan(lat, h, w, e, inc, stray, pb, pd);
        compared++; if (lat != 17) begin mismatched++; $display("FAIL inv_latency: got %0d want 17", lat); end
        compared++; if (h !== 1'b0) begin mismatched++; $display("FAIL inv_hit: got %b want 0", h); end
        compared++; if (w !== llc_way_t'(3)) begin mismatched++; $display("FAIL inv_way: got %0d want 3", w); end
        compared++; if ({e, inc} !== 2'b00) begin mismatched++; $display("FAIL inv_evict_incr: got %b want 00", {e, inc}); end
        compared++; if (stray != 0) begin mismatched++; $display("FAIL inv_stray_incr: got %0d want 0", stray); end
    endtask

    task automatic test_evict();
        int lat, stray; logic h, e, inc, pb, pd; llc_way_t w;
        fill_all_valid();
        evict_way_buf = llc_way_t'(LLC_WAYS - 1);
        do_scan(lat, h, w, e, inc, stray, pb, pd);
        compared++; if (lat != 17) begin mismatched++; $display("FAIL evict_latency: got %0d want 17", lat); end
        compared++; if (w !== llc_way_t'(LLC_WAYS - 1)) begin mismatched++; $display("FAIL evict_way: got %0d want %0d", w, LLC_WAYS - 1); end
        compared++; if ({h, e, inc} !== 3'b011) begin mismatched++; $display("FAIL evict_flags: hit/evict/incr got %b want 011", {h, e, inc}); end
        compared++; if (stray != 0) begin mismatched++; $display("FAIL evict_incr_width: extra pulses got %0d want 0", stray); end
    endtask

    task automatic test_abort();
        int dones = 0;
        int lat, stray; logic h, e, inc, pb, pd; llc_way_t w;
        fill_all_valid();
        states_buf[11] = LLC_INVALID;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_state = 1'b1;
        @(posedge clk); #1; rst_state = 1'b0;
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL abort_idle: busy/done got %b want 00", {busy, done}); end
        compared++; if ({hit, evict, incr_evict_way_buf, way} !== '0) begin mismatched++; $display("FAIL abort_outputs: got hit=%b evict=%b incr=%b way=%0d want all 0", hit, evict, incr_evict_way_buf, way); end
        repeat (25) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        compared++; if (dones != 0) begin mismatched++; $display("FAIL abort_no_done: got %0d dones want 0", dones); end
        start = 1'b1; rst_state = 1'b1;
        @(posedge clk); #1; start = 1'b0; rst_state = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_state_beats_start: busy got %b want 0", busy); end
        do_scan(lat, h, w, e, inc, stray, pb, pd);
        compared++; if (lat != 17 || h !== 1'b0 || w !== llc_way_t'(11) || e !== 1'b0) begin mismatched++; $display("FAIL abort_restart: lat=%0d hit=%b way=%0d evict=%b want 17/0/11/0", lat, h, w, e); end
    endtask

    task automatic test_busy_start();
        int dones = 0;
        int first = 0;
        fill_all_valid();
        states_buf[6] = LLC_INVALID;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (done === 1'b1) begin dones++; if (first == 0) first = n; end
            start = (n == 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        compared++; if (dones != 1) begin mismatched++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
        compared++; if (first != 17) begin mismatched++; $display("FAIL busy_start_latency: got %0d want 17", first); end
    endtask

    task automatic test_hit_way0();
        int lat, stray; logic h, e, inc, pb, pd; llc_way_t w;
        fill_all_valid();
        tags_buf[0] = 16'h003A;
        tags_buf[8] = 16'h003A;
        do_scan(lat, h, w, e, inc, stray, pb, pd);
        compared++; if (lat != (EARLY ? 2 : 17)) begin mismatched++; $display("FAIL way0_latency: got %0d want %0d", lat, EARLY ? 2 : 17); end
        compared++; if (h !== 1'b1 || w !== llc_way_t'(0) || e !== 1'b0) begin mismatched++; $display("FAIL way0_result: hit=%b way=%0d evict=%b want 1/0/0", h, w, e); end
    endtask

    task automatic test_random();
        int lat, stray, m_lat, pinv; logic h, e, inc, pb, pd, m_hit, m_evict; llc_way_t w, m_way;
        for (int it = 0; it < 40; it++) begin
            pinv = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 6 : 30);
            req_tag = llc_tag_t'($urandom_range(0, 7));
            for (int i = 0; i < LLC_WAYS; i++) begin
                tags_buf[i]   = llc_tag_t'($urandom_range(0, (it % 2 == 0) ? 7 : 40));
                states_buf[i] = ($urandom_range(0, 99) < pinv) ? LLC_INVALID
                                : llc_state_t'($urandom_range(1, 7));
            end
            evict_way_buf = llc_way_t'($urandom_range(0, LLC_WAYS - 1));
            model(m_hit, m_way, m_evict, m_lat);
            do_scan(lat, h, w, e, inc, stray, pb, pd);
            compared++; if (lat != m_lat) begin mismatched++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, m_lat); end
            compared++; if (h !== m_hit) begin mismatched++; $display("FAIL rand%0d_hit: got %b want %b", it, h, m_hit); end
            compared++; if (w !== m_way) begin mismatched++; $display("FAIL rand%0d_way: got %0d want %0d", it, w, m_way); end
            compared++; if (e !== m_evict || inc !== m_evict) begin mismatched++; $display("FAIL rand%0d_evict_incr: got %b%b want %b%b", it, e, inc, m_evict, m_evict); end
            compared++; if (stray != 0 || pb !== 1'b0 || pd !== 1'b0) begin mismatched++; $display("FAIL rand%0d_after_done: stray=%0d busy=%b done=%b want 0/0/0", it, stray, pb, pd); end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_invalid_fill();
        test_evict();
        test_abort();
        test_busy_start();
        test_hit_way0();
        test_reset_midscan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
